// File: rtl/tft_pkg.sv
// Shared constants and types for the TFT SPI target.
package tft_pkg;

  localparam logic [7:0] CmdNop     = 8'h00;
  localparam logic [7:0] CmdSwreset = 8'h01;
  localparam logic [7:0] CmdCaset   = 8'h2A;
  localparam logic [7:0] CmdPaset   = 8'h2B;
  localparam logic [7:0] CmdRamwr   = 8'h2C;

  typedef enum logic [2:0] {
    StIdle,
    StCaset,
    StPaset,
    StRamwr,
    StSkip
  } dec_state_e;

  // One received byte with the D/C flag sampled on its last bit.
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_byte_t;

  // A window is legal when it is non-empty and ends inside the panel.
  function automatic logic win_ok(input logic [15:0] win_start, input logic [15:0] win_end,
                                  input int unsigned limit);
    return (win_start <= win_end) && ({16'd0, win_end} < limit);
  endfunction

endpackage

// File: rtl/spi_rx.sv
// Pin synchronizers, SCK rising-edge detect and byte assembly.
module spi_rx
  import tft_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     tft_sck_i,
  input  logic     tft_sdi_i,
  input  logic     tft_dc_i,
  input  logic     tft_cs_i,
  output logic     byte_valid_o,
  output rx_byte_t rx_byte_o
);

  // Bit order {cs, dc, sdi, sck}; chip select resets deasserted.
  localparam logic [3:0] PinRst = 4'b1000;

  logic [3:0] sync_q [SyncStages];
  logic [3:0] pins_s;
  logic       sck_q;
  logic [6:0] shift_q;
  logic [2:0] cnt_q;

  assign pins_s = sync_q[SyncStages-1];

  // Synchronizer chain shared by all four pins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= PinRst;
    end else begin
      sync_q[0] <= {tft_cs_i, tft_dc_i, tft_sdi_i, tft_sck_i};
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Shift on each SCK rise while selected; deselect drops any partial byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q        <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      byte_valid_o <= 1'b0;
      rx_byte_o    <= '0;
    end else begin
      byte_valid_o <= 1'b0;
      sck_q        <= pins_s[0];
      if (pins_s[3]) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (pins_s[0] && !sck_q) begin
        shift_q <= {shift_q[5:0], pins_s[1]};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_valid_o   <= 1'b1;
          rx_byte_o.dc   <= pins_s[2];
          rx_byte_o.data <= {shift_q, pins_s[1]};
        end
      end
    end
  end

endmodule

// File: rtl/tft_spi_target.sv
// SPI display target: decodes CASET/PASET/RAMWR into addressed RGB565 pixels.
module tft_spi_target
  import tft_pkg::*;
#(
  parameter int unsigned NUM_COLS    = 240,
  parameter int unsigned NUM_ROWS    = 320,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        tft_sck,
  input  logic                        tft_sdi,
  input  logic                        tft_dc,
  input  logic                        tft_cs,
  output logic                        pixel_valid_out,
  output logic [$clog2(NUM_COLS)-1:0] pixel_col_out,
  output logic [$clog2(NUM_ROWS)-1:0] pixel_row_out,
  output logic [15:0]                 pixel_color_out,
  output logic                        cmd_valid_out,
  output logic [7:0]                  cmd_out,
  output logic                        err_out
);

  localparam int unsigned ColW = $clog2(NUM_COLS);
  localparam int unsigned RowW = $clog2(NUM_ROWS);
  localparam logic [ColW-1:0] ColMax = ColW'(NUM_COLS - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(NUM_ROWS - 1);

  logic       rx_valid;
  rx_byte_t   rx_byte;

  spi_rx #(
    .SyncStages (SYNC_STAGES)
  ) u_spi_rx (
    .clk_i        (clk_in),
    .rst_ni       (rst_n_in),
    .tft_sck_i    (tft_sck),
    .tft_sdi_i    (tft_sdi),
    .tft_dc_i     (tft_dc),
    .tft_cs_i     (tft_cs),
    .byte_valid_o (rx_valid),
    .rx_byte_o    (rx_byte)
  );

  dec_state_e      state_q;
  logic [2:0]      param_cnt_q;
  logic [23:0]     param_q;
  logic [ColW-1:0] col_start_q, col_end_q, col_ptr_q;
  logic [RowW-1:0] row_start_q, row_end_q, row_ptr_q;
  logic            half_q;
  logic [7:0]      hi_q;

  // The 4th parameter byte completes the window end value.
  logic [15:0] win_start, win_end;
  logic        col_ok, row_ok;

  assign win_start = param_q[23:8];
  assign win_end   = {param_q[7:0], rx_byte.data};
  assign col_ok    = win_ok(win_start, win_end, NUM_COLS);
  assign row_ok    = win_ok(win_start, win_end, NUM_ROWS);

  // Command decoder, window registers, pixel pointer and registered pulse outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= StIdle;
      param_cnt_q     <= '0;
      param_q         <= '0;
      col_start_q     <= '0;
      col_end_q       <= ColMax;
      row_start_q     <= '0;
      row_end_q       <= RowMax;
      col_ptr_q       <= '0;
      row_ptr_q       <= '0;
      half_q          <= 1'b0;
      hi_q            <= '0;
      pixel_valid_out <= 1'b0;
      pixel_col_out   <= '0;
      pixel_row_out   <= '0;
      pixel_color_out <= '0;
      cmd_valid_out   <= 1'b0;
      cmd_out         <= '0;
      err_out         <= 1'b0;
    end else begin
      pixel_valid_out <= 1'b0;
      cmd_valid_out   <= 1'b0;
      err_out         <= 1'b0;
      if (rx_valid && !rx_byte.dc) begin
        cmd_valid_out <= 1'b1;
        cmd_out       <= rx_byte.data;
        param_cnt_q   <= '0;
        half_q        <= 1'b0;  // a half-received pixel is dropped
        case (rx_byte.data)
          CmdCaset: state_q <= StCaset;
          CmdPaset: state_q <= StPaset;
          CmdRamwr: begin
            state_q   <= StRamwr;
            col_ptr_q <= col_start_q;
            row_ptr_q <= row_start_q;
          end
          CmdSwreset: begin
            state_q     <= StSkip;
            col_start_q <= '0;
            col_end_q   <= ColMax;
            row_start_q <= '0;
            row_end_q   <= RowMax;
            col_ptr_q   <= '0;
            row_ptr_q   <= '0;
          end
          default: state_q <= StSkip;
        endcase
      end else if (rx_valid) begin
        case (state_q)
          StCaset, StPaset: begin
            // Counter saturates at 4 so trailing parameters are ignored.
            if (param_cnt_q != 3'd4) begin
              param_cnt_q <= param_cnt_q + 3'd1;
              param_q     <= {param_q[15:0], rx_byte.data};
              if (param_cnt_q == 3'd3) begin
                if (state_q == StCaset) begin
                  if (col_ok) begin
                    col_start_q <= win_start[ColW-1:0];
                    col_end_q   <= win_end[ColW-1:0];
                  end else begin
                    err_out <= 1'b1;
                  end
                end else begin
                  if (row_ok) begin
                    row_start_q <= win_start[RowW-1:0];
                    row_end_q   <= win_end[RowW-1:0];
                  end else begin
                    err_out <= 1'b1;
                  end
                end
              end
            end
          end
          StRamwr: begin
            if (!half_q) begin
              hi_q   <= rx_byte.data;
              half_q <= 1'b1;
            end else begin
              half_q          <= 1'b0;
              pixel_valid_out <= 1'b1;
              pixel_color_out <= {hi_q, rx_byte.data};
              pixel_col_out   <= col_ptr_q;
              pixel_row_out   <= row_ptr_q;
              if (col_ptr_q == col_end_q) begin
                col_ptr_q <= col_start_q;
                row_ptr_q <= (row_ptr_q == row_end_q) ? row_start_q : row_ptr_q + RowW'(1);
              end else begin
                col_ptr_q <= col_ptr_q + ColW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tft_spi_target.sv
// Directed bench for tft_spi_target: drives SPI byte streams and checks decoded pixels.
module tb_tft_spi_target;

  localparam int unsigned NUM_COLS = 240;
  localparam int unsigned NUM_ROWS = 320;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        tft_sck  = 1'b0;
  logic        tft_sdi  = 1'b0;
  logic        tft_dc   = 1'b0;
  logic        tft_cs   = 1'b1;
  logic        pixel_valid_out;
  logic [7:0]  pixel_col_out;
  logic [8:0]  pixel_row_out;
  logic [15:0] pixel_color_out;
  logic        cmd_valid_out;
  logic [7:0]  cmd_out;
  logic        err_out;

  tft_spi_target #(
    .NUM_COLS    (NUM_COLS),
    .NUM_ROWS    (NUM_ROWS),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .tft_sck         (tft_sck),
    .tft_sdi         (tft_sdi),
    .tft_dc          (tft_dc),
    .tft_cs          (tft_cs),
    .pixel_valid_out (pixel_valid_out),
    .pixel_col_out   (pixel_col_out),
    .pixel_row_out   (pixel_row_out),
    .pixel_color_out (pixel_color_out),
    .cmd_valid_out   (cmd_valid_out),
    .cmd_out         (cmd_out),
    .err_out         (err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  int pix_col[$];
  int pix_row[$];
  int pix_color[$];
  int err_cnt = 0;
  int cmd_cnt = 0;
  int pv_run  = 0;
  int pv_max  = 0;

  // Record output pulses on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (pixel_valid_out) begin
      pix_col.push_back(int'(pixel_col_out));
      pix_row.push_back(int'(pixel_row_out));
      pix_color.push_back(int'(pixel_color_out));
      pv_run = pv_run + 1;
      if (pv_run > pv_max) pv_max = pv_run;
    end else begin
      pv_run = 0;
    end
    if (err_out) err_cnt = err_cnt + 1;
    if (cmd_valid_out) cmd_cnt = cmd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic spi_bit(input logic dc, input logic b);
    tft_dc  = dc;
    tft_sdi = b;
    wait_clk(5);
    tft_sck = 1'b1;
    wait_clk(5);
    tft_sck = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    tft_cs = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(dc, b[i]);
  endtask

  task automatic send_win(input logic [7:0] cmd, input logic [15:0] ws, input logic [15:0] we);
    send_byte(1'b0, cmd);
    send_byte(1'b1, ws[15:8]);
    send_byte(1'b1, ws[7:0]);
    send_byte(1'b1, we[15:8]);
    send_byte(1'b1, we[7:0]);
  endtask

  task automatic end_xfer();
    wait_clk(4);
    tft_cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_pixel(input string tag, input int idx, input int c, input int r,
                             input int color);
    if (idx < pix_col.size()) begin
      check_eq({tag, "_col"}, pix_col[idx], c);
      check_eq({tag, "_row"}, pix_row[idx], r);
      check_eq({tag, "_color"}, pix_color[idx], color);
    end else begin
      check_eq({tag, "_present"}, pix_col.size(), idx + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pv"}, pixel_valid_out, 0);
    check_eq({tag, "_cv"}, cmd_valid_out, 0);
    check_eq({tag, "_err"}, err_out, 0);
    check_eq({tag, "_cmd"}, cmd_out, 0);
    check_eq({tag, "_col"}, pixel_col_out, 0);
    check_eq({tag, "_row"}, pixel_row_out, 0);
    check_eq({tag, "_color"}, pixel_color_out, 0);
  endtask

  int exp_col[7] = '{10, 11, 12, 10, 11, 12, 10};
  int exp_row[7] = '{20, 20, 20, 21, 21, 21, 20};
  int base;
  int cmd_base;

  initial begin
    wait_clk(3);
    check_reset_outputs("rst");
    rst_n_in = 1'b1;
    wait_clk(4);

    // Window 10..12 x 20..21, seven pixels, the last one wraps.
    send_win(8'h2A, 16'd10, 16'd12);
    send_win(8'h2B, 16'd20, 16'd21);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 7; i++) begin
      send_byte(1'b1, 8'hA5);
      send_byte(1'b1, 8'(i));
    end
    end_xfer();
    check_eq("t1_npix", pix_col.size(), 7);
    for (int i = 0; i < 7; i++) check_pixel($sformatf("t1_p%0d", i), i, exp_col[i], exp_row[i],
                                             32'hA500 + i);
    check_eq("t1_ncmd", cmd_cnt, 3);
    check_eq("t1_cmd", cmd_out, 32'h2C);
    check_eq("t1_nerr", err_cnt, 0);

    // start > end is rejected; window stays at column 10.
    base = pix_col.size();
    send_win(8'h2A, 16'd50, 16'd40);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h34);
    end_xfer();
    check_eq("t2_nerr", err_cnt, 1);
    check_pixel("t2_pix", base, 10, 20, 32'h1234);

    // end = 240 is out of range, end = 239 is the last legal column.
    send_win(8'h2A, 16'd0, 16'h00F0);
    end_xfer();
    check_eq("t3_rej", err_cnt, 2);
    send_win(8'h2A, 16'd0, 16'h00EF);
    end_xfer();
    check_eq("t3_acc", err_cnt, 2);

    // Partial byte aborted by CS, then a clean RAMWR.
    base     = pix_col.size();
    cmd_base = cmd_cnt;
    tft_cs   = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1);
    wait_clk(4);
    tft_cs = 1'b1;
    wait_clk(10);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h56);
    send_byte(1'b1, 8'h78);
    end_xfer();
    check_eq("t4_ncmd", cmd_cnt, cmd_base + 1);
    check_eq("t4_cmd", cmd_out, 32'h2C);
    check_pixel("t4_pix", base, 0, 20, 32'h5678);

    // Reset in the middle of a pixel; later data lands in IDLE.
    base = pix_col.size();
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB);
    wait_clk(4);
    rst_n_in = 1'b0;
    tft_cs   = 1'b1;
    wait_clk(3);
    check_reset_outputs("t5_rst");
    rst_n_in = 1'b1;
    wait_clk(4);
    send_byte(1'b1, 8'h9A);
    send_byte(1'b1, 8'hBC);
    end_xfer();
    check_eq("t5_npix", pix_col.size(), base);

    // Odd byte dropped by a new command; red pixel at reset origin.
    base   = pix_col.size();
    pv_max = 0;
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h77);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hF8);
    send_byte(1'b1, 8'h00);
    end_xfer();
    check_eq("t6_npix", pix_col.size(), base + 1);
    check_pixel("t6_pix", base, 0, 0, 32'hF800);
    check_eq("t6_width", pv_max, 1);

    // Software reset restores the full window and origin.
    base = pix_col.size();
    send_win(8'h2A, 16'd5, 16'd6);
    send_win(8'h2B, 16'd7, 16'd8);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h33);
    end_xfer();
    check_pixel("t7_pix", base, 0, 0, 32'h2233);
    check_eq("t7_cmd", cmd_out, 32'h2C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
